vreg_xbar: RTL and testbench

//  Parametrised lane-to-register-bank crossbar for one vector core.
//  NUM_LANES lanes issue read/write requests to NUM_BANKS register-file banks. Each bank has its own

---
 rtl/vreg_xbar.sv | 149 ++++++++++++++
 tb/tb_vreg_xbar.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_xbar.sv
`default_nettype none
// ============================================================================
//  Module   : vreg_xbar
//  Purpose  : Lane-to-register-bank crossbar for one vector core. Each bank
//             has its own round-robin arbiter. The bank access is registered,
//             and read data returns to the requesting lane 3 cycles after
//             the request is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module vreg_xbar #(
   parameter int NUM_LANES = 4,
   parameter int NUM_BANKS = 4,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 64,
   localparam int BANK_W   = $clog2(NUM_BANKS),
   localparam int IN_W     = ADDR_W - BANK_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_LANES-1:0]        req_valid,
   output logic [NUM_LANES-1:0]        req_ready,
   input  logic [NUM_LANES-1:0]        req_we,
   input  logic [NUM_LANES*ADDR_W-1:0] req_addr,
   input  logic [NUM_LANES*DATA_W-1:0] req_wdata,
   output logic [NUM_LANES-1:0]        rsp_valid,
   output logic [NUM_LANES*DATA_W-1:0] rsp_rdata,
   output logic [NUM_BANKS-1:0]        bank_valid,
   output logic [NUM_BANKS-1:0]        bank_we,
   output logic [NUM_BANKS*IN_W-1:0]   bank_addr,
   output logic [NUM_BANKS*DATA_W-1:0] bank_wdata,
   input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata
);

   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   logic [BANK_W-1:0] lane_bank [NUM_LANES];
   logic [LANE_W-1:0] rr_ptr    [NUM_BANKS];
   logic [LANE_W-1:0] win_lane  [NUM_BANKS];
   logic [NUM_BANKS-1:0] win_any;

   logic              sel_we    [NUM_BANKS];
   logic [IN_W-1:0]   sel_addr  [NUM_BANKS];
   logic [DATA_W-1:0] sel_wdata [NUM_BANKS];

   // Tag pipe: stage 1 travels with the bank strobe, stage 2 lines up with bank_rdata
   logic [NUM_BANKS-1:0] s1_rd;
   logic [NUM_BANKS-1:0] s2_rd;
   logic [LANE_W-1:0]    s1_lane [NUM_BANKS];
   logic [LANE_W-1:0]    s2_lane [NUM_BANKS];

   logic [NUM_LANES-1:0] rsp_hit;
   logic [DATA_W-1:0]    rsp_sel [NUM_LANES];

   generate
      for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane_bank
         assign lane_bank[l] = req_addr[l*ADDR_W +: BANK_W];
      end
   endgenerate

   // Per-bank round-robin: first requesting lane at or after the bank's pointer wins
   always_comb begin
      int idx;
      idx       = 0;
      win_any   = '0;
      req_ready = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         win_lane[b] = '0;
         for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(rr_ptr[b]) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!win_any[b] && req_valid[idx] && (lane_bank[idx] == BANK_W'(b))) begin
               win_any[b]  = 1'b1;
               win_lane[b] = LANE_W'(idx);
            end
         end
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (win_any[b]) req_ready[win_lane[b]] = 1'b1;
      end
   end

   // Route the winning lane's command fields onto each bank
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         sel_we[b]    = req_we[win_lane[b]];
         sel_addr[b]  = req_addr[int'(win_lane[b])*ADDR_W + BANK_W +: IN_W];
         sel_wdata[b] = req_wdata[int'(win_lane[b])*DATA_W +: DATA_W];
      end
   end

   // Bank command stage, arbiter pointers and the response tag pipe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bank_valid <= '0;
         bank_we    <= '0;
         bank_addr  <= '0;
         bank_wdata <= '0;
         s1_rd      <= '0;
         s2_rd      <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            rr_ptr[b]  <= '0;
            s1_lane[b] <= '0;
            s2_lane[b] <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            bank_valid[b] <= win_any[b];
            bank_we[b]    <= win_any[b] & sel_we[b];
            s1_rd[b]      <= win_any[b] & ~sel_we[b];
            s1_lane[b]    <= win_lane[b];
            s2_rd[b]      <= s1_rd[b];
            s2_lane[b]    <= s1_lane[b];
            if (win_any[b]) begin
               bank_addr[b*IN_W +: IN_W]      <= sel_addr[b];
               bank_wdata[b*DATA_W +: DATA_W] <= sel_wdata[b];
               if (int'(win_lane[b]) == NUM_LANES - 1) rr_ptr[b] <= '0;
               else                                    rr_ptr[b] <= win_lane[b] + 1'b1;
            end
         end
      end
   end

   // Steer each bank's returning read data to the lane recorded in its tag
   always_comb begin
      rsp_hit = '0;
      for (int l = 0; l < NUM_LANES; l++) rsp_sel[l] = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (s2_rd[b]) begin
            rsp_hit[s2_lane[b]] = 1'b1;
            rsp_sel[s2_lane[b]] = bank_rdata[b*DATA_W +: DATA_W];
         end
      end
   end

   // Response register; data holds its last value while rsp_valid is low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= rsp_hit;
         for (int l = 0; l < NUM_LANES; l++) begin
            if (rsp_hit[l]) rsp_rdata[l*DATA_W +: DATA_W] <= rsp_sel[l];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vreg_xbar.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vreg_xbar
//  Purpose  : Self-checking bench for vreg_xbar: directed vectors, corner
//             sequences and random traffic against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vreg_xbar;
   localparam int NL = 4;
   localparam int NB = 4;
   localparam int AW = 8;
   localparam int DW = 64;
   localparam int BW = 2;
   localparam int IW = AW - BW;

   logic clk = 1'b0;
   logic reset;
   logic [NL-1:0]    req_valid, req_ready, req_we, rsp_valid;
   logic [NL*AW-1:0] req_addr;
   logic [NL*DW-1:0] req_wdata, rsp_rdata;
   logic [NB-1:0]    bank_valid, bank_we;
   logic [NB*IW-1:0] bank_addr;
   logic [NB*DW-1:0] bank_wdata, bank_rdata;

   logic [AW-1:0] l_addr  [NL];
   logic [DW-1:0] l_wdata [NL];

   vreg_xbar #(.NUM_LANES(NL), .NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .bank_valid(bank_valid), .bank_we(bank_we), .bank_addr(bank_addr),
      .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
   );

   always #5 clk = ~clk;

   // Pack per-lane stimulus onto the flat request buses
   always_comb begin
      for (int l = 0; l < NL; l++) begin
         req_addr[l*AW +: AW]  = l_addr[l];
         req_wdata[l*DW +: DW] = l_wdata[l];
      end
   end

   function automatic logic [DW-1:0] pat(input int b, input int i);
      logic [31:0] h;
      h = (b * 64 + i) * 32'h9E3779B9;
      return {16'hC0DE, b[7:0], i[7:0], h};
   endfunction

   // Register-file banks: reloaded with a known pattern while reset is held
   logic [DW-1:0] env_mem [NB][64];
   logic [DW-1:0] env_rd  [NB];
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (!reset) begin
            for (int i = 0; i < 64; i++) env_mem[b][i] <= pat(b, i);
            env_rd[b] <= '0;
         end else if (bank_valid[b]) begin
            if (bank_we[b]) env_mem[b][bank_addr[b*IW +: IW]] <= bank_wdata[b*DW +: DW];
            else            env_rd[b] <= env_mem[b][bank_addr[b*IW +: IW]];
         end
      end
   end
   always_comb begin
      for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = env_rd[b];
   end

   // ---------------- reference model ----------------
   typedef struct { int due; int lane; logic [DW-1:0] data; } rsp_t;
   rsp_t          rq[$];
   int            rr_m   [NB];
   logic [DW-1:0] mm     [NB][64];
   logic          pb_v   [NB];
   logic          pb_we  [NB];
   logic [IW-1:0] pb_addr[NB];
   logic [DW-1:0] pb_wd  [NB];
   logic [DW-1:0] exp_last[NL];
   int            waitc  [NL];
   logic [NL-1:0] last_acc;
   int            cyc;
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      rq.delete();
      last_acc = '0;
      for (int b = 0; b < NB; b++) begin
         rr_m[b] = 0;
         pb_v[b] = 1'b0;
         for (int i = 0; i < 64; i++) mm[b][i] = pat(b, i);
      end
      for (int l = 0; l < NL; l++) begin
         exp_last[l] = '0;
         waitc[l]    = 0;
      end
   endtask

   // Winner per bank = requesting lane with smallest circular distance from the pointer
   function automatic logic [NL-1:0] model_ready();
      logic [NL-1:0] r;
      int best, bestd, d;
      r = '0;
      for (int b = 0; b < NB; b++) begin
         best = -1; bestd = NL;
         for (int l = 0; l < NL; l++) begin
            if (req_valid[l] && int'(l_addr[l][BW-1:0]) == b) begin
               d = (l - rr_m[b] + NL) % NL;
               if (d < bestd) begin bestd = d; best = l; end
            end
         end
         if (best >= 0) r[best] = 1'b1;
      end
      return r;
   endfunction

   // One clock: check every output at the falling edge, then advance the model
   task automatic step();
      logic [NL-1:0] er, ev;
      logic [NB-1:0] ebv;
      int b, idx;
      @(negedge clk);
      cyc++;
      er = model_ready();
      chk("req_ready", req_ready, er);
      ebv = '0;
      for (int k = 0; k < NB; k++) ebv[k] = pb_v[k];
      chk("bank_valid", bank_valid, ebv);
      for (int k = 0; k < NB; k++) begin
         if (pb_v[k]) begin
            chk("bank_we", bank_we[k], pb_we[k]);
            chk("bank_addr", bank_addr[k*IW +: IW], pb_addr[k]);
            if (pb_we[k]) chk("bank_wdata", bank_wdata[k*DW +: DW], pb_wd[k]);
         end
      end
      ev = '0;
      for (int i = rq.size() - 1; i >= 0; i--) begin
         if (rq[i].due == cyc) begin
            ev[rq[i].lane]       = 1'b1;
            exp_last[rq[i].lane] = rq[i].data;
            rq.delete(i);
         end
      end
      chk("rsp_valid", rsp_valid, ev);
      for (int l = 0; l < NL; l++) chk("rsp_rdata", rsp_rdata[l*DW +: DW], exp_last[l]);
      for (int k = 0; k < NB; k++) pb_v[k] = 1'b0;
      for (int l = 0; l < NL; l++) begin
         if (er[l]) begin
            b   = int'(l_addr[l][BW-1:0]);
            idx = int'(l_addr[l][AW-1:BW]);
            pb_v[b] = 1'b1; pb_we[b] = req_we[l];
            pb_addr[b] = l_addr[l][AW-1:BW]; pb_wd[b] = l_wdata[l];
            if (req_we[l]) mm[b][idx] = l_wdata[l];
            else rq.push_back('{cyc + 3, l, mm[b][idx]});
            rr_m[b] = (l + 1) % NL;
         end
         if (req_valid[l]) begin
            if (er[l]) begin
               n_cmp++;
               if (waitc[l] + 1 > NL) begin
                  n_err++;
                  $display("FAIL fairness lane %0d: waited %0d cycles, limit %0d", l, waitc[l] + 1, NL);
               end
               waitc[l] = 0;
            end else waitc[l]++;
         end else waitc[l] = 0;
      end
      last_acc = er;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      model_reset();
   endtask

   task automatic set_lane(input int l, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[l] = 1'b1; req_we[l] = we; l_addr[l] = a; l_wdata[l] = d;
   endtask

   task automatic gen(input bit rd_only);
      for (int l = 0; l < NL; l++) begin
         if (req_valid[l] && !last_acc[l]) begin
            if (rd_only && req_we[l]) req_valid[l] = 1'b0;
         end else if ($urandom_range(0, 9) < 7) begin
            set_lane(l, !rd_only && ($urandom_range(0, 9) < 3), 8'($urandom_range(0, 255)),
                     {$urandom, $urandom});
         end else req_valid[l] = 1'b0;
      end
   endtask

   typedef struct {
      logic [NL-1:0] v; logic [NL-1:0] we; logic [AW-1:0] a [NL];
      logic [NL-1:0] exp_rdy; logic [NB-1:0] exp_bv; logic [NB-1:0] exp_bwe;
   } vec_t;
   vec_t vecs[7];

   initial begin
      logic [NL-1:0] eg;
      reset = 1'b0; req_valid = '0; req_we = '0; cyc = 0;
      for (int l = 0; l < NL; l++) begin l_addr[l] = '0; l_wdata[l] = '0; end
      model_reset();

      vecs[0] = '{4'b1111, 4'b0000, '{8'h05, 8'h06, 8'h07, 8'h04}, 4'b1111, 4'b1111, 4'b0000};
      vecs[1] = '{4'b1111, 4'b0000, '{8'h02, 8'h06, 8'h0A, 8'h0E}, 4'b0001, 4'b0100, 4'b0000};
      vecs[2] = '{4'b1110, 4'b1110, '{8'h02, 8'h06, 8'h0A, 8'h0E}, 4'b0010, 4'b0100, 4'b0100};
      vecs[3] = '{4'b1010, 4'b0000, '{8'h01, 8'h00, 8'h03, 8'h04}, 4'b0010, 4'b0001, 4'b0000};
      vecs[4] = '{4'b0000, 4'b0000, '{8'h01, 8'h02, 8'h03, 8'h04}, 4'b0000, 4'b0000, 4'b0000};
      vecs[5] = '{4'b1101, 4'b1000, '{8'h11, 8'h20, 8'h22, 8'h33}, 4'b1101, 4'b1110, 4'b1000};
      vecs[6] = '{4'b1111, 4'b0000, '{8'h03, 8'h07, 8'h01, 8'h05}, 4'b0101, 4'b1010, 4'b0000};

      // Table-driven arbitration vectors, each from the reset pointer state
      for (int i = 0; i < 7; i++) begin
         do_reset();
         for (int l = 0; l < NL; l++) begin
            l_addr[l] = vecs[i].a[l]; l_wdata[l] = {32'hABCD0000, 32'(i * 16 + l)};
         end
         req_valid = vecs[i].v; req_we = vecs[i].we;
         #1 chk("vec_ready", req_ready, vecs[i].exp_rdy);
         step();
         req_valid = '0;
         chk("vec_bank_valid", bank_valid, vecs[i].exp_bv);
         chk("vec_bank_we", bank_we, vecs[i].exp_bwe);
         repeat (3) step();
      end

      // Single read after a write of 0xDEAD to addr 0x05 (bank 1, in-bank 1)
      do_reset();
      set_lane(0, 1'b1, 8'h05, 64'hDEAD);
      step();
      set_lane(0, 1'b0, 8'h05, 64'h0);
      #1 chk("single_ready0", req_ready[0], 1'b1);
      step();
      req_valid = '0;
      chk("single_bank_valid", bank_valid, 4'b0010);
      chk("single_bank_addr", bank_addr[1*IW +: IW], 6'h01);
      repeat (2) step();
      chk("single_rsp_valid", rsp_valid, 4'b0001);
      chk("single_rsp_rdata", rsp_rdata[0 +: DW], 64'hDEAD);
      step();

      // All lanes hammer bank 2: grants rotate 0,1,2,3,0,...
      do_reset();
      for (int l = 0; l < NL; l++) set_lane(l, 1'b0, 8'((l << 2) | 2), '0);
      #1;
      for (int i = 0; i < 8; i++) begin
         eg = '0; eg[i % NL] = 1'b1;
         chk("conflict_grant", req_ready, eg);
         step();
      end
      req_valid = '0;
      repeat (4) step();

      // Parallel: lane l targets bank l with in-bank address l+1
      do_reset();
      for (int l = 0; l < NL; l++) set_lane(l, 1'b0, 8'(((l + 1) << 2) | l), '0);
      #1 chk("par_ready", req_ready, 4'b1111);
      step();
      req_valid = '0;
      chk("par_bank_valid", bank_valid, 4'b1111);
      repeat (2) step();
      chk("par_rsp_valid", rsp_valid, 4'b1111);
      for (int l = 0; l < NL; l++) chk("par_rsp_rdata", rsp_rdata[l*DW +: DW], pat(l, l + 1));
      step();

      // Write from lane 2 to 0x0E: bank 2, in-bank 3, and no response
      set_lane(2, 1'b1, 8'h0E, 64'h1234);
      #1 chk("wr_ready", req_ready, 4'b0100);
      step();
      req_valid = '0;
      chk("wr_bank_valid", bank_valid, 4'b0100);
      chk("wr_bank_we", bank_we, 4'b0100);
      chk("wr_bank_addr", bank_addr[2*IW +: IW], 6'h03);
      chk("wr_bank_wdata", bank_wdata[2*DW +: DW], 64'h1234);
      repeat (2) step();
      chk("wr_no_rsp", rsp_valid[2], 1'b0);
      step();

      // Random traffic, with an asynchronous reset while reads are in flight
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         gen(k >= 694 && k < 700);
         step();
         if (k == 699) begin
            #2 reset = 1'b0;
            req_valid = '0;
            #1;
            chk("rst_bank_valid", bank_valid, '0);
            chk("rst_bank_we", bank_we, '0);
            chk("rst_bank_addr", bank_addr, '0);
            chk("rst_bank_wdata", {63'b0, |bank_wdata}, '0);
            chk("rst_rsp_valid", rsp_valid, '0);
            chk("rst_rsp_rdata", {63'b0, |rsp_rdata}, '0);
            @(posedge clk);
            #1 reset = 1'b1;
            model_reset();
         end
      end
      req_valid = '0;
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
